// File: rtl/word_ram_split.sv
// word_ram_split: byte-addressed word RAM, read/write port 1 with boundary-crossing split, read-only port 2.
module word_ram_split #(
    parameter int SIZE_WORDS = 8192,
    parameter int ADDR_WIDTH = $clog2(4*SIZE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [31:0]           wdata_1,
    input  logic [3:0]            wstrb_1,
    output logic                  ready_1,
    output logic                  rvalid_1,
    output logic [31:0]           rdata_1,
    input  logic                  req_2,
    input  logic [ADDR_WIDTH-1:0] addr_2,
    output logic                  rvalid_2,
    output logic [31:0]           rdata_2
);
    localparam int WW = ADDR_WIDTH - 2;
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state, state_nx;
    logic [31:0] mem [SIZE_WORDS];
    logic [WW-1:0] w, w_nx, hi_w;
    logic [1:0] off, hi_off;
    logic [63:0] wd64, rd64;
    logic [7:0] ws8;
    logic [3:0] hi_strb;
    logic [31:0] hi_data, lo_word;
    logic hi_rd, accept, is_rd, span, rd_now, rd_split;
    logic unused_addr_2;
    assign unused_addr_2 = ^addr_2[1:0];
    assign w = addr_1[ADDR_WIDTH-1:2];
    assign off = addr_1[1:0];
    assign w_nx = (w == WW'(SIZE_WORDS-1)) ? '0 : w + WW'(1);
    // Lanes shifted into a two-word window: low half is beat 1, high half is beat 2.
    assign wd64 = {32'b0, wdata_1} << {off, 3'b0};
    assign ws8 = {4'b0, wstrb_1} << off;
    assign rd64 = {mem[hi_w], lo_word} >> {hi_off, 3'b0};
    assign is_rd = wstrb_1 == 4'b0;
    assign span = is_rd ? off != 2'b0 : |ws8[7:4];
    assign ready_1 = state == IDLE && !rst;
    assign accept = req_1 && ready_1;
    assign rd_now = accept && is_rd && !span;
    assign rd_split = state == SPLIT && hi_rd && !rst;
    always_comb begin
        state_nx = (state == IDLE && accept && span) ? SPLIT : IDLE;
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (accept && ws8[b]) mem[w][8*b +: 8] <= wd64[8*b +: 8];
            if (state == SPLIT && !rst && hi_strb[b]) mem[hi_w][8*b +: 8] <= hi_data[8*b +: 8];
        end
        if (accept) begin
            hi_w <= w_nx;
            hi_off <= off;
            hi_strb <= ws8[7:4];
            hi_data <= wd64[63:32];
            lo_word <= mem[w];
            hi_rd <= is_rd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_1 <= 1'b0;
            rdata_1 <= '0;
            rvalid_2 <= 1'b0;
            rdata_2 <= '0;
        end else begin
            rvalid_1 <= rd_now || rd_split;
            rdata_1 <= rd_now ? mem[w] : rd_split ? rd64[31:0] : rdata_1;
            rvalid_2 <= req_2;
            if (req_2) rdata_2 <= mem[addr_2[ADDR_WIDTH-1:2]];
        end
    end
endmodule

// File: tb/tb_word_ram_split.sv
// tb_word_ram_split: directed checks of word_ram_split with hand-computed expectations.
module tb_word_ram_split;
    localparam int AW = 15;
    logic clk = 0, rst = 1;
    logic req_1 = 0, req_2 = 0;
    logic [AW-1:0] addr_1 = '0, addr_2 = '0;
    logic [31:0] wdata_1 = '0;
    logic [3:0] wstrb_1 = '0;
    logic ready_1, rvalid_1, rvalid_2;
    logic [31:0] rdata_1, rdata_2;
    int checks = 0, failures = 0;

    word_ram_split dut (
        .clk(clk), .rst(rst),
        .req_1(req_1), .addr_1(addr_1), .wdata_1(wdata_1), .wstrb_1(wstrb_1),
        .ready_1(ready_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .req_2(req_2), .addr_2(addr_2), .rvalid_2(rvalid_2), .rdata_2(rdata_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one port-1 request and returns just after its accepting edge.
    task automatic p1(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!ready_1 && n < 10) begin
            step();
            n++;
        end
        if (n == 10) chk("ready_timeout", 32'(ready_1), 32'd1);
        req_1 = 1; addr_1 = a; wdata_1 = d; wstrb_1 = s;
        step();
        req_1 = 0; wstrb_1 = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        p1(a, d, s);
        if (!ready_1) step();
    endtask

    task automatic rd2(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        req_2 = 1; addr_2 = a;
        step();
        req_2 = 0;
        chk({tag, "_v"}, 32'(rvalid_2), 32'd1);
        chk(tag, rdata_2, exp);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_ready", 32'(ready_1), 32'd0);
        chk("rst_rvalid_1", 32'(rvalid_1), 32'd0);
        chk("rst_rvalid_2", 32'(rvalid_2), 32'd0);
        chk("rst_rdata_1", rdata_1, 32'd0);
        chk("rst_rdata_2", rdata_2, 32'd0);
        rst = 0;
        #1;
        chk("ready_after_rst", 32'(ready_1), 32'd1);

        wr(15'h10, 32'hDEADBEEF, 4'hF);
        chk("aligned_wr_ready", 32'(ready_1), 32'd1);
        chk("wr_no_rvalid", 32'(rvalid_1), 32'd0);
        p1(15'h10, 32'h0, 4'h0);
        chk("aligned_rd_v", 32'(rvalid_1), 32'd1);
        chk("aligned_rd", rdata_1, 32'hDEADBEEF);
        step();
        chk("rvalid_pulse", 32'(rvalid_1), 32'd0);
        chk("rdata_hold", rdata_1, 32'hDEADBEEF);
        rd2("p2_ignore_low", 15'h13, 32'hDEADBEEF);

        wr(15'h10, 32'h33221100, 4'hF);
        wr(15'h14, 32'h77665544, 4'hF);
        p1(15'h12, 32'h0, 4'h0);
        chk("span_rd_busy", 32'(ready_1), 32'd0);
        chk("span_rd_early", 32'(rvalid_1), 32'd0);
        step();
        chk("span_rd_v", 32'(rvalid_1), 32'd1);
        chk("span_rd", rdata_1, 32'h55443322);
        chk("span_rd_ready", 32'(ready_1), 32'd1);

        wr(15'h10, 32'h0, 4'hF);
        wr(15'h14, 32'h0, 4'hF);
        p1(15'h13, 32'hAABBCCDD, 4'h3);
        chk("span_wr_busy", 32'(ready_1), 32'd0);
        step();
        chk("span_wr_no_rvalid", 32'(rvalid_1), 32'd0);
        rd2("span_wr_w4", 15'h10, 32'hDD000000);
        rd2("span_wr_w5", 15'h14, 32'h000000CC);
        p1(15'h11, 32'h0000BBAA, 4'h3);
        chk("off_wr_nospan", 32'(ready_1), 32'd1);
        rd2("off_wr_w4", 15'h10, 32'hDDBBAA00);

        wr(15'h7FFC, 32'hD4C3B2A1, 4'hF);
        wr(15'h0, 32'h11223344, 4'hF);
        p1(15'h7FFE, 32'h0, 4'h0);
        step();
        chk("wrap_rd_v", 32'(rvalid_1), 32'd1);
        chk("wrap_rd", rdata_1, 32'h3344D4C3);

        wr(15'h1C, 32'h0, 4'hF);
        req_1 = 1; addr_1 = 15'h1C; wdata_1 = 32'h1; wstrb_1 = 4'hF;
        req_2 = 1; addr_2 = 15'h1C;
        step();
        req_1 = 0; wstrb_1 = 0; req_2 = 0;
        chk("collide_v", 32'(rvalid_2), 32'd1);
        chk("collide_old", rdata_2, 32'h0);
        rd2("collide_new", 15'h1C, 32'h1);

        wr(15'h10, 32'h0, 4'hF);
        wr(15'h14, 32'h0, 4'hF);
        p1(15'h13, 32'hAABBCCDD, 4'hF);
        chk("split_entered", 32'(ready_1), 32'd0);
        rst = 1;
        step();
        chk("abort_rvalid_1", 32'(rvalid_1), 32'd0);
        chk("abort_ready", 32'(ready_1), 32'd0);
        chk("abort_rdata_1", rdata_1, 32'h0);
        chk("abort_rdata_2", rdata_2, 32'h0);
        chk("abort_rvalid_2", 32'(rvalid_2), 32'd0);
        rst = 0;
        step();
        chk("abort_no_late_rvalid", 32'(rvalid_1), 32'd0);
        chk("abort_ready_back", 32'(ready_1), 32'd1);
        rd2("abort_w4", 15'h10, 32'hDD000000);
        rd2("abort_w5", 15'h14, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/word_ram_split.md
# word_ram_split

Byte-addressed word RAM with a read/write data port and an independent read-only fetch port. Both ports have registered reads. Port 1 handles misaligned accesses that cross a word boundary by splitting them into two internal beats. The block replaces the single-port combinational-read RAM as unified instruction/data memory behind the CPU core.

## Interface
- `SIZE_WORDS`, default 8192: number of 32-bit words.
- `ADDR_WIDTH`, default `$clog2(4*SIZE_WORDS)`: byte-address width.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_1` in 1: port 1 request.
- `addr_1` in ADDR_WIDTH: port 1 byte address.
- `wdata_1` in 32: port 1 write data; lane i is byte address `addr_1+i`.
- `wstrb_1` in 4: port 1 byte-lane write strobes; 0 = read.
- `ready_1` out 1: port 1 can accept a request this cycle.
- `rvalid_1` out 1: port 1 read data valid, one-cycle pulse.
- `rdata_1` out 32: port 1 read data; lane i is byte `addr_1+i`.
- `req_2` in 1: port 2 read request.
- `addr_2` in ADDR_WIDTH: port 2 byte address; bits [1:0] ignored.
- `rvalid_2` out 1: port 2 read data valid.
- `rdata_2` out 32: port 2 read data.

## Operation
- Addressing:
  - `w = addr[ADDR_WIDTH-1:2]`, `off = addr[1:0]`.
  - Byte b of word w sits at bits `[8b+7:8b]`.
  - Word index arithmetic is modulo SIZE_WORDS, so w+1 past the last word wraps to word 0.
- Port 1 accept: `req_1 & ready_1`. `ready_1 = (state == IDLE) & ~rst`.
- Spanning rule:
  - A read spans iff `off != 0`.
  - A write spans iff some lane j with `wstrb_1[j]` set has `off+j > 3`.
- FSM states: IDLE, SPLIT.
  - IDLE, non-spanning accept: single beat, stay in IDLE.
  - IDLE, spanning accept: latch w+1, off, strobes, wdata and the partial read data, then go to SPLIT.
  - SPLIT: perform the second beat, then always return to IDLE. No other transitions.
- Writes:
  - Beat 1 writes lanes with `off+j <= 3` to word w, byte `off+j`.
  - Beat 2 writes lanes with `off+j > 3` to word w+1, byte `off+j-4`.
  - Unstrobed bytes are preserved.
- Reads:
  - `rdata_1` byte i = byte `(off+i)` of the 64-bit concatenation {word w+1, word w}.
  - For non-spanning reads this is simply word w.
- Writes produce no `rvalid_1`.
- Port 2:
  - Accepted every cycle while `req_2` is high; no backpressure.
  - Returns word `addr_2[ADDR_WIDTH-1:2]`.
- Port collisions:
  - Port 1 write and port 2 read to the same word in the same cycle: port 2 returns the pre-write value (read-first).
  - Port 1 read after its own write always sees the new data, since every write commits on its beat edge.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, `rvalid_1=0`, `rvalid_2=0`, `rdata_1=0`, `rdata_2=0`, `ready_1=0` while `rst` is high.
- Non-spanning read accepted at edge T: `rvalid_1` and `rdata_1` valid in cycle T+1.
- Spanning read accepted at T:
  - `ready_1=0` in cycle T+1.
  - `rvalid_1` in cycle T+2.
  - `ready_1=1` again in T+2.
- Spanning write accepted at T: word w updated at T, word w+1 updated at the next edge; `ready_1=0` for one cycle.
- Port 2: request at edge T gives `rvalid_2`/`rdata_2` in T+1. Back-to-back requests give one word per cycle.
- `rdata_1`/`rdata_2` hold their last value when the matching rvalid is low.
- Reset asserted in SPLIT:
  - Second beat aborted; word w+1 is not written.
  - No `rvalid_1` is issued.
  - Beat 1 write remains committed.
- A request presented while `ready_1=0` is not accepted; the requester holds it.

## Test plan
- Aligned write then read:
  - Stimulus: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then read 0x10.
  - Required: `rvalid_1` one cycle after accept with rdata 0xDEADBEEF.
  - Port 2 read of 0x13 also returns 0xDEADBEEF.
- Spanning read:
  - Setup: word 4 = 0x33221100, word 5 = 0x77665544.
  - Stimulus: read addr 0x12.
  - Required: `ready_1` low one cycle; `rvalid_1` two cycles after accept with 0x55443322.
- Spanning partial write:
  - Setup: words 4 and 5 = 0.
  - Stimulus: write addr 0x13, wdata 0xAABBCCDD, wstrb 0x3.
  - Required: word 4 = 0xDD000000, word 5 = 0x000000CC.
- Wrap and collision:
  - Stimulus: spanning read at byte `4*SIZE_WORDS-2`.
  - Required: upper two bytes come from word 0.
  - Stimulus: port 1 writes 0x1 to word 7 while port 2 reads word 7 (old value 0x0).
  - Required: port 2 returns 0x0 that cycle; the following port 2 read returns 0x1.
- Reset mid-split:
  - Setup: words 4 and 5 = 0.
  - Stimulus: assert `rst` during SPLIT of write addr 0x13, wstrb 0xF, wdata 0xAABBCCDD.
  - Required: word 4 = 0xDD000000, word 5 unchanged, no `rvalid_1`, all outputs at reset values.
